// File: rtl/pulse_stretch.sv
// pulse_stretch: single-cycle trigger to a delayed, stretched strobe
// followed by a hold-off window; reports busy and dropped triggers.
module pulse_stretch #(
    parameter int CNT_W   = 8,
    parameter int DELAY   = 2,
    parameter int WIDTH   = 4,
    parameter int HOLDOFF = 3,
    parameter bit RETRIG  = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic IN,
    output logic OUT,
    output logic BUSY,
    output logic DROP
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DLY  = 2'd1,
        ACT  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DLY_LD = CNT_W'((DELAY > 0) ? DELAY - 1 : 0);
    localparam logic [CNT_W-1:0] WID_LD = CNT_W'((WIDTH > 0) ? WIDTH - 1 : 0);
    localparam logic [CNT_W-1:0] HLD_LD = CNT_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    localparam bit PARAM_OK = (WIDTH >= 1) && (DELAY >= 0) && (HOLDOFF >= 0)
                           && (DELAY < 2**CNT_W) && (WIDTH < 2**CNT_W)
                           && (HOLDOFF < 2**CNT_W);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drop_q, drop_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drop_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (IN) begin
                    if (DELAY > 0) begin
                        state_d = DLY;
                        cnt_d   = DLY_LD;
                    end else begin
                        state_d = ACT;
                        cnt_d   = WID_LD;
                    end
                end
            end
            DLY: begin
                drop_d = IN;
                if (cnt_zero) begin
                    state_d = ACT;
                    cnt_d   = WID_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACT: begin
                // a retrigger also wins over the exit on the last ACT edge
                if (IN && RETRIG) begin
                    cnt_d = WID_LD;
                end else begin
                    drop_d = IN;
                    if (cnt_zero) begin
                        if (HOLDOFF > 0) begin
                            state_d = HOLD;
                            cnt_d   = HLD_LD;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            HOLD: begin
                drop_d = IN;
                if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
        end
    end

    assign OUT  = (state_q == ACT);
    assign BUSY = (state_q != IDLE);
    assign DROP = drop_q;

    param_chk: assert property (@(posedge CLK) PARAM_OK);

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: five configurations against a timestamp model.
module tb_pulse_stretch;

    localparam int N = 5;
    localparam int PD [N] = '{2, 2, 0, 0, 3};
    localparam int PW [N] = '{4, 4, 1, 1, 2};
    localparam int PH [N] = '{3, 3, 0, 0, 1};
    localparam int PR [N] = '{0, 1, 0, 1, 0};

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    logic IN = 1'b0;
    logic [N-1:0] o_out, o_busy, o_drop;

    int n_cmp = 0;
    int n_bad = 0;
    bit en = 1'b0;

    always #5 CLK = ~CLK;

    pulse_stretch #(.CNT_W(8), .DELAY(2), .WIDTH(4), .HOLDOFF(3), .RETRIG(1'b0)) u0 (
        .CLK(CLK), .RST_N(RST_N), .IN(IN),
        .OUT(o_out[0]), .BUSY(o_busy[0]), .DROP(o_drop[0]));
    pulse_stretch #(.CNT_W(8), .DELAY(2), .WIDTH(4), .HOLDOFF(3), .RETRIG(1'b1)) u1 (
        .CLK(CLK), .RST_N(RST_N), .IN(IN),
        .OUT(o_out[1]), .BUSY(o_busy[1]), .DROP(o_drop[1]));
    pulse_stretch #(.CNT_W(8), .DELAY(0), .WIDTH(1), .HOLDOFF(0), .RETRIG(1'b0)) u2 (
        .CLK(CLK), .RST_N(RST_N), .IN(IN),
        .OUT(o_out[2]), .BUSY(o_busy[2]), .DROP(o_drop[2]));
    pulse_stretch #(.CNT_W(8), .DELAY(0), .WIDTH(1), .HOLDOFF(0), .RETRIG(1'b1)) u3 (
        .CLK(CLK), .RST_N(RST_N), .IN(IN),
        .OUT(o_out[3]), .BUSY(o_busy[3]), .DROP(o_drop[3]));
    pulse_stretch #(.CNT_W(8), .DELAY(3), .WIDTH(2), .HOLDOFF(1), .RETRIG(1'b0)) u4 (
        .CLK(CLK), .RST_N(RST_N), .IN(IN),
        .OUT(o_out[4]), .BUSY(o_busy[4]), .DROP(o_drop[4]));

    // Model: per config, edge of acceptance, OUT window [os, oe), busy end.
    longint cyc = 0;
    longint t0 [N];
    longint os [N];
    longint oe [N];
    longint bend [N];
    logic [N-1:0] xdrop = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            t0[i] = -1000; os[i] = -1000; oe[i] = -1000; bend[i] = -1000;
        end
    end

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cyc   <= 0;
            xdrop <= '0;
            for (int i = 0; i < N; i++) begin
                t0[i] <= -1000; os[i] <= -1000; oe[i] <= -1000; bend[i] <= -1000;
            end
        end else begin
            cyc   <= cyc + 1;
            xdrop <= '0;
            if (IN) begin
                for (int i = 0; i < N; i++) begin
                    if (cyc + 1 > bend[i]) begin
                        t0[i]   <= cyc + 1;
                        os[i]   <= cyc + 1 + PD[i];
                        oe[i]   <= cyc + 1 + PD[i] + PW[i];
                        bend[i] <= cyc + 1 + PD[i] + PW[i] + PH[i];
                    end else if (PR[i] != 0 && cyc + 1 > os[i] && cyc + 1 <= oe[i]) begin
                        oe[i]   <= cyc + 1 + PW[i];
                        bend[i] <= cyc + 1 + PW[i] + PH[i];
                    end else begin
                        xdrop[i] <= 1'b1;
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input int d, input logic a, input logic x);
        n_cmp++;
        if (a !== x) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc %0d: got %b want %b", nm, d, cyc, a, x);
        end
    endtask

    logic [N-1:0] hout [64];
    logic [N-1:0] hbusy [64];
    logic [N-1:0] hdrop [64];

    always @(negedge CLK) begin
        if (en) begin
            for (int i = 0; i < N; i++) begin
                check("out", i, o_out[i], (cyc >= os[i]) && (cyc < oe[i]));
                check("busy", i, o_busy[i], (cyc >= t0[i]) && (cyc < bend[i]));
                check("drop", i, o_drop[i], xdrop[i]);
            end
            if (cyc >= 0 && cyc < 64) begin
                hout[cyc]  = o_out;
                hbusy[cyc] = o_busy;
                hdrop[cyc] = o_drop;
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            IN = i[0];
            @(negedge CLK);
        end
        #1;
        check("rst_out", 0, |o_out, 1'b0);
        check("rst_busy", 0, |o_busy, 1'b0);
        check("rst_drop", 0, |o_drop, 1'b0);
        IN = 1'b0;
        RST_N = 1'b1;
    endtask

    task automatic play(input logic [63:0] m, input int n);
        for (int e = 1; e <= n; e++) begin
            IN = m[e];
            @(posedge CLK);
            @(negedge CLK);
        end
        IN = 1'b0;
        #1;
    endtask

    function automatic logic any_set(input int d, input int lo, input int hi, input int sel);
        logic r;
        r = 1'b0;
        for (int e = lo; e <= hi; e++) begin
            if (sel == 0) r = r | hout[e][d];
            else if (sel == 1) r = r | hbusy[e][d];
            else r = r | hdrop[e][d];
        end
        return r;
    endfunction

    initial begin
        int dens;
        #1;
        RST_N = 1'b0;
        en = 1'b1;

        do_reset();
        play(64'd0, 20);
        check("idle_out", 0, |{any_set(0, 1, 20, 0), any_set(2, 1, 20, 0)}, 1'b0);
        check("idle_busy", 0, any_set(0, 1, 20, 1), 1'b0);

        do_reset();
        play(64'd1 << 10, 30);
        check("A_out11", 0, hout[11][0], 1'b0);
        check("A_out12", 0, hout[12][0], 1'b1);
        check("A_out15", 0, hout[15][0], 1'b1);
        check("A_out16", 0, hout[16][0], 1'b0);
        check("A_busy9", 0, hbusy[9][0], 1'b0);
        check("A_busy10", 0, hbusy[10][0], 1'b1);
        check("A_busy18", 0, hbusy[18][0], 1'b1);
        check("A_busy19", 0, hbusy[19][0], 1'b0);
        check("A_nodrop", 0, any_set(0, 1, 30, 2), 1'b0);

        do_reset();
        play((64'd1 << 10) | (64'd1 << 13), 30);
        check("B_drop13", 0, hdrop[13][0], 1'b1);
        check("B_drop14", 0, hdrop[14][0], 1'b0);
        check("B_out15", 0, hout[15][0], 1'b1);
        check("B_out16", 0, hout[16][0], 1'b0);
        check("B_rt_out16", 1, hout[16][1], 1'b1);
        check("B_rt_out17", 1, hout[17][1], 1'b0);
        check("B_rt_busy19", 1, hbusy[19][1], 1'b1);
        check("B_rt_busy20", 1, hbusy[20][1], 1'b0);
        check("B_rt_nodrop", 1, any_set(1, 1, 30, 2), 1'b0);

        do_reset();
        play((64'd1 << 10) | (64'd1 << 17), 30);
        check("C_drop17", 0, hdrop[17][0], 1'b1);
        check("C_drop18", 0, hdrop[18][0], 1'b0);
        check("C_busy18", 0, hbusy[18][0], 1'b1);
        check("C_busy19", 0, hbusy[19][0], 1'b0);

        do_reset();
        play((64'd1 << 5) | (64'd1 << 6), 30);
        check("D_out5", 2, hout[5][2], 1'b1);
        check("D_out6", 2, hout[6][2], 1'b0);
        check("D_drop6", 2, hdrop[6][2], 1'b1);
        check("D_busy6", 2, hbusy[6][2], 1'b0);
        check("D_rt_out6", 3, hout[6][3], 1'b1);
        check("D_rt_out7", 3, hout[7][3], 1'b0);
        check("D_rt_drop6", 3, hdrop[6][3], 1'b0);

        do_reset();
        play(64'd1 << 10, 13);
        check("E_pre_out", 0, o_out[0], 1'b1);
        RST_N = 1'b0;
        #1;
        check("E_async_out", 0, o_out[0], 1'b0);
        check("E_async_busy", 0, o_busy[0], 1'b0);
        @(negedge CLK);
        #1;
        RST_N = 1'b1;
        play(64'd0, 20);
        check("E_post_out", 0, any_set(0, 1, 20, 0), 1'b0);
        check("E_post_busy", 0, any_set(0, 1, 20, 1), 1'b0);

        dens = 30;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) dens = $urandom_range(5, 90);
            IN = ($urandom_range(0, 99) < dens);
            @(posedge CLK);
            @(negedge CLK);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                RST_N = 1'b0;
                #1;
                RST_N = 1'b1;
            end
        end
        IN = 1'b0;
        repeat (12) @(negedge CLK);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
